// File: rtl/mesh_term_injector.sv
// Per-terminal mesh packet injector: assembles {nxt_jmp,row,col,mode,payload} packets into a FWFT FIFO.
// Optional INJ_TSTAMP_EN: a free-running 16-bit cycle stamp replaces payload[15:0] at accept.
module mesh_term_injector #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int term_id    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_row,
    input  logic [3:0]                    in_col,
    input  logic                          in_mode,
    input  logic [pckg_sz-18:0]           in_payload,
    output logic                          pndng,
    output logic [pckg_sz-1:0]            data_out,
    input  logic                          popin,
    output logic [$clog2(fifo_depth):0]   count,
    output logic [15:0]                   bad_dst_cnt,
    output logic                          underflow,
    output logic [7:0]                    dbg
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int PW = pckg_sz - 17;
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [pckg_sz-1:0] r_data_out;
    logic [15:0]        r_bad_cnt;
    logic               r_underflow;
    logic               r_live;

    logic               w_full;
    logic               w_empty;
    logic               w_legal;
    logic               w_acc;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [AW-1:0]      w_rd_nxt;
    logic [PW-1:0]      w_payload;
    logic [pckg_sz-1:0] w_pkt;

`ifdef INJ_TSTAMP_EN
    logic [15:0] r_tstamp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tstamp <= 16'h0000;
        end else begin
            r_tstamp <= r_tstamp + 16'h0001;
        end
    end

    assign w_payload = {in_payload[PW-1:16], r_tstamp};
`else
    assign w_payload = in_payload;
`endif

    // Valid/ready: a request transfers on any edge where in_valid && in_ready; in_ready comes
    // from registered state only, so it never combinationally depends on in_valid or popin.
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign in_ready = r_live && !w_full;

    // Legal endpoints are the edge terminals around the 4x4 core: rows/cols 0 and 5.
    always_comb begin
        w_legal = 1'b0;
        if (((in_row == 4'd0) || (in_row == 4'd5)) && (in_col >= 4'd1) && (in_col <= 4'd4)) begin
            w_legal = 1'b1;
        end
        if (((in_col == 4'd0) || (in_col == 4'd5)) && (in_row >= 4'd1) && (in_row <= 4'd4)) begin
            w_legal = 1'b1;
        end
    end

    assign w_acc    = in_valid && in_ready;
    assign w_push   = w_acc && w_legal;
    assign w_drop   = w_acc && !w_legal;
    assign w_pop    = popin && !w_empty;
    assign w_rd_nxt = r_rd_ptr + 1'b1;
    assign w_pkt    = {8'h00, in_row, in_col, in_mode, w_payload};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_bad_cnt   <= 16'h0000;
            r_underflow <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // data_out is a registered copy of the head so it keeps the last head once drained.
            if (w_push && (w_empty || ((r_count == CW'(1)) && w_pop))) begin
                r_data_out <= w_pkt;
            end else if (w_pop && (r_count > CW'(1))) begin
                r_data_out <= r_mem[w_rd_nxt];
            end
            if (w_drop && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'h0001;
            end
            if (popin && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pndng       = !w_empty;
    assign data_out    = r_data_out;
    assign count       = r_count;
    assign bad_dst_cnt = r_bad_cnt;
    assign underflow   = r_underflow;
    assign dbg         = {4'(term_id), r_live, w_full, w_empty, r_underflow};

endmodule

// File: tb/tb_mesh_term_injector.sv
// Scoreboard bench for mesh_term_injector: reference queue of legal packets, checked on every cycle.
module tb_mesh_term_injector;
  localparam int P  = 40;
  localparam int D  = 4;
  localparam int PW = P - 17;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_row;
  logic [3:0]    in_col;
  logic          in_mode;
  logic [PW-1:0] in_payload;
  logic          pndng;
  logic [P-1:0]  data_out;
  logic          popin;
  logic [2:0]    count;
  logic [15:0]   bad_dst_cnt;
  logic          underflow;
  logic [7:0]    dbg;

  always #5 clk = ~clk;

  mesh_term_injector #(.pckg_sz(P), .fifo_depth(D), .term_id(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_col      (in_col),
    .in_mode     (in_mode),
    .in_payload  (in_payload),
    .pndng       (pndng),
    .data_out    (data_out),
    .popin       (popin),
    .count       (count),
    .bad_dst_cnt (bad_dst_cnt),
    .underflow   (underflow),
    .dbg         (dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [P-1:0] exp_q[$];
  logic [P-1:0] last_head;
  logic [15:0]  exp_bad;
  logic         exp_uf;
  logic         live;
  int           n_cmp;
  int           n_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

`ifdef INJ_TSTAMP_EN
  logic [15:0] tb_ts;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_ts <= 16'h0000;
    else        tb_ts <= tb_ts + 16'h0001;
  end
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic legal_dst(input logic [3:0] r, input logic [3:0] c);
    return (((r == 4'd0) || (r == 4'd5)) && (c >= 4'd1) && (c <= 4'd4)) ||
           (((c == 4'd0) || (c == 4'd5)) && (r >= 4'd1) && (r <= 4'd4));
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, check pre-edge outputs, update model, check post-edge state.
  task automatic step(input logic v, input logic [3:0] r, input logic [3:0] c, input logic m,
                      input logic [PW-1:0] pl, input logic pop, output logic acc);
    logic [P-1:0]  pkt;
    logic [PW-1:0] mpl;
    logic          exp_rdy;
    @(negedge clk);
    in_valid = v; in_row = r; in_col = c; in_mode = m; in_payload = pl; popin = pop;
    #1;
    exp_rdy = live && (exp_q.size() < D);
    check("in_ready", in_ready, exp_rdy);
    check("pndng", pndng, exp_q.size() != 0);
    check("head", data_out, (exp_q.size() != 0) ? exp_q[0] : last_head);
    mpl = pl;
`ifdef INJ_TSTAMP_EN
    mpl[15:0] = tb_ts;
`endif
    pkt = {8'h00, r, c, m, mpl};
    acc = v && exp_rdy;
    if (pop) begin
      if (exp_q.size() != 0) last_head = exp_q.pop_front();
      else                   exp_uf = 1'b1;
    end
    if (acc) begin
      if (legal_dst(r, c)) begin
        if (exp_q.size() == 0) last_head = pkt;
        exp_q.push_back(pkt);
      end else if (exp_bad != 16'hFFFF) begin
        exp_bad++;
      end
    end
    @(posedge clk);
    #1;
    check("count", count, exp_q.size());
    check("bad_dst_cnt", bad_dst_cnt, exp_bad);
    check("underflow", underflow, exp_uf);
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] c, input logic [PW-1:0] pl,
                      output logic acc);
    step(1'b1, r, c, pl[0], pl, 1'b0, acc);
  endtask

  task automatic idle(input logic pop);
    logic acc;
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, pop, acc);
  endtask

  task automatic drain();
    int budget;
    budget = 4 * D;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    check("drain_budget", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] dst_r[8] = '{4'd0, 4'd5, 4'd1, 4'd4, 4'd0, 4'd5, 4'd2, 4'd3};
  logic [3:0] dst_c[8] = '{4'd1, 4'd4, 4'd0, 4'd5, 4'd4, 4'd2, 4'd5, 4'd0};

  initial begin
    logic acc;
    n_cmp = 0; n_err = 0;
    exp_bad = 16'h0000; exp_uf = 1'b0; last_head = '0;

    // T1: reset held with in_valid asserted
    reset = 1'b0; in_valid = 1'b1; in_row = 4'd0; in_col = 4'd2; in_mode = 1'b1;
    in_payload = 23'h1234; popin = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pndng", pndng, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_data_out", data_out, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rdy_before_first_edge", in_ready, 0);

    // T2: single packet, exact format
    step(1'b1, 4'd0, 4'd2, 1'b1, 23'h1234, 1'b0, acc);
    check("t2_accept", acc, 1);
    check("t2_data", data_out, 40'h00_0_2_801234);
    idle(1'b1);
    idle(1'b0);
    check("t2_hold_last", data_out, 40'h00_0_2_801234);

    // T3: fill to full, blocked 5th, one pop frees a slot
    for (int i = 0; i < D; i++) begin
      push(dst_r[i], dst_c[i], 23'(16'hA000 + i), acc);
      check("t3_fill_acc", acc, 1);
    end
    check("t3_count_full", count, D);
    push(dst_r[4], dst_c[4], 23'h0E0E0E, acc);
    check("t3_blocked", in_ready, 0);
    step(1'b1, dst_r[4], dst_c[4], 1'b0, 23'h0E0E0E, 1'b1, acc);
    push(dst_r[4], dst_c[4], 23'h0E0E0E, acc);
    check("t3_fifth_acc", acc, 1);
    drain();

    // T4: illegal destinations dropped; boundary corners
    push(4'd3, 4'd3, 23'h111, acc);
    push(4'd0, 4'd0, 23'h222, acc);
    check("t4_bad2", bad_dst_cnt, 2);
    check("t4_pndng", pndng, 0);
    push(4'd0, 4'd5, 23'h333, acc);
    push(4'd1, 4'd1, 23'h444, acc);
    push(4'd5, 4'd4, 23'h555, acc);
    push(4'd4, 4'd0, 23'h666, acc);
    push(4'd0, 4'd1, 23'h777, acc);
    push(4'd6, 4'd0, 23'h888, acc);
    drain();

    // T5: steady push+pop at count=2
    push(dst_r[0], dst_c[0], 23'h50, acc);
    push(dst_r[1], dst_c[1], 23'h51, acc);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, dst_r[(i + 2) % 8], dst_c[(i + 2) % 8], i[0], 23'(32'h60 + i), 1'b1, acc);
      check("t5_count", count, 2);
    end
    drain();

    // push+pop on empty: push lands, pop ignored (sets underflow)
    step(1'b1, 4'd5, 4'd1, 1'b1, 23'h7ABCD, 1'b1, acc);
    check("empty_pushpop_pndng", pndng, 1);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
           1'($urandom_range(0, 1)), 23'($urandom_range(0, 32'h7FFFFF)),
           ($urandom_range(0, 2) != 0), acc);
    end
    drain();

    // T6: underflow, then async reset with 3 queued
    idle(1'b1);
    check("t6_underflow", underflow, 1);
    for (int i = 0; i < 3; i++) push(dst_r[i], dst_c[i], 23'(32'h900 + i), acc);
    check("t6_count3", count, 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_pndng", pndng, 0);
    check("t6_async_uf", underflow, 0);
    check("t6_async_data", data_out, 0);
    check("t6_async_bad", bad_dst_cnt, 0);
    exp_q.delete();
    exp_bad = 16'h0000; exp_uf = 1'b0; last_head = '0;
    in_valid = 1'b0; popin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0);
    push(4'd2, 4'd5, 23'h4242, acc);
    check("post_reset_acc", acc, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
